// File: rtl/shared_pkg.sv
// Shared types and default sizing for the SPI RAM command path.
package shared_pkg;

  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;
  localparam int DEF_MEM_WIDTH = 8;
  localparam bit DEF_AUTO_INC  = 1'b1;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } control_e;

  typedef struct packed {
    control_e                 ctrl;
    logic [DEF_MEM_WIDTH-1:0] payload;
  } rx_data_s;

endpackage

// File: rtl/spi_ram_array.sv
// Single-port storage, registered read, no reset; rdata holds between reads.
module spi_ram_array #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_burst_ram.sv
// RAM command engine: decodes {control_e, payload} words, owns pointers and armed flags.
module spi_burst_ram
  import shared_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int MEM_WIDTH = DEF_MEM_WIDTH,
  parameter bit AUTO_INC  = DEF_AUTO_INC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [MEM_WIDTH+1:0] din,
  input  logic                 rx_valid,
  output logic [MEM_WIDTH-1:0] dout,
  output logic                 tx_valid,
  output logic                 err
);

  control_e               cmd;
  logic [MEM_WIDTH-1:0]   payload;
  logic [ADDR_SIZE-1:0]   addr;
  logic                   addr_bad;

  logic [ADDR_SIZE-1:0]   wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic                   wr_armed, rd_armed, wr_armed_d, rd_armed_d;
  logic                   err_d, rd_go, dout_clr;
  logic                   ram_en, ram_we;
  logic [ADDR_SIZE-1:0]   ram_addr;
  logic [MEM_WIDTH-1:0]   ram_rdata;

  assign cmd      = control_e'(din[MEM_WIDTH+1:MEM_WIDTH]);
  assign payload  = din[MEM_WIDTH-1:0];
  assign addr     = payload[ADDR_SIZE-1:0];
  assign addr_bad = ({1'b0, addr} >= (ADDR_SIZE+1)'(MEM_DEPTH));

  function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
    return (p == ADDR_SIZE'(MEM_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = rd_ptr;
    wr_ptr_d   = wr_ptr;
    rd_ptr_d   = rd_ptr;
    wr_armed_d = wr_armed;
    rd_armed_d = rd_armed;
    err_d      = 1'b0;
    rd_go      = 1'b0;
    if (rx_valid) begin
      unique case (cmd)
        WR_ADDR: begin
          if (addr_bad) err_d = 1'b1;
          else begin
            wr_ptr_d   = addr;
            wr_armed_d = 1'b1;
          end
        end
        WR_DATA: begin
          if (!wr_armed) err_d = 1'b1;
          else begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = wr_ptr;
            if (AUTO_INC) wr_ptr_d = next_ptr(wr_ptr);
          end
        end
        RD_ADDR: begin
          if (addr_bad) err_d = 1'b1;
          else begin
            rd_ptr_d   = addr;
            rd_armed_d = 1'b1;
          end
        end
        RD_DATA: begin
          if (!rd_armed) err_d = 1'b1;
          else begin
            ram_en   = 1'b1;
            rd_go    = 1'b1;
            ram_addr = rd_ptr;
            if (AUTO_INC) rd_ptr_d = next_ptr(rd_ptr);
          end
        end
      endcase
    end
  end

  // The array has no reset, so dout is forced to zero until the first read after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_armed <= 1'b0;
      rd_armed <= 1'b0;
      err      <= 1'b0;
      tx_valid <= 1'b0;
      dout_clr <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      wr_armed <= wr_armed_d;
      rd_armed <= rd_armed_d;
      err      <= err_d;
      tx_valid <= rd_go;
      if (rd_go) dout_clr <= 1'b0;
    end
  end

  assign dout = dout_clr ? '0 : ram_rdata;

  spi_ram_array #(
    .DEPTH(MEM_DEPTH),
    .WIDTH(MEM_WIDTH),
    .AW   (ADDR_SIZE)
  ) u_array (
    .clk  (clk),
    .en   (ram_en & rst_n),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(payload),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed bench for spi_burst_ram: default, depth-200 and no-increment instances.
module tb_spi_burst_ram;
  import shared_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] din [3];
  logic       rxv [3];
  logic [7:0] dout [3];
  logic       txv [3];
  logic       err [3];

  logic [7:0] sb [$];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_burst_ram u0 (
    .clk(clk), .rst_n(rst_n), .din(din[0]), .rx_valid(rxv[0]),
    .dout(dout[0]), .tx_valid(txv[0]), .err(err[0]));

  spi_burst_ram #(.MEM_DEPTH(200)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din[1]), .rx_valid(rxv[1]),
    .dout(dout[1]), .tx_valid(txv[1]), .err(err[1]));

  spi_burst_ram #(.AUTO_INC(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .din(din[2]), .rx_valid(rxv[2]),
    .dout(dout[2]), .tx_valid(txv[2]), .err(err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one command at a falling edge, let it be accepted, then check the registered outputs.
  task automatic send(input int d, input control_e c, input logic [7:0] pl,
                      input logic exp_err, input string tag);
    logic [7:0] exp_d;
    din[d] = {c, pl};
    rxv[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rxv[d] = 1'b0;
    din[d] = '0;
    check({tag, " err"}, err[d], exp_err);
    check({tag, " tx_valid"}, txv[d], (sb.size() > 0));
    if (sb.size() > 0) begin
      exp_d = sb.pop_front();
      check({tag, " dout"}, dout[d], exp_d);
    end
  endtask

  task automatic rd(input int d, input logic [7:0] exp_d, input string tag);
    sb.push_back(exp_d);
    send(d, RD_DATA, 8'h00, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) begin
      check({tag, " dout"}, dout[d], 8'h00);
      check({tag, " tx_valid"}, txv[d], 1'b0);
      check({tag, " err"}, err[d], 1'b0);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      din[d] = '0;
      rxv[d] = 1'b0;
    end
    @(negedge clk);
    do_reset("reset0");

    // depth 200: out-of-range address rejected, burst wraps at C7
    send(1, WR_ADDR, 8'hC8, 1'b1, "d200 wr_addr C8");
    send(1, WR_DATA, 8'h55, 1'b1, "d200 unarmed wr_data");
    send(1, WR_ADDR, 8'hC7, 1'b0, "d200 wr_addr C7");
    send(1, WR_DATA, 8'h01, 1'b0, "d200 wr C7");
    send(1, WR_DATA, 8'h02, 1'b0, "d200 wr 00");
    send(1, RD_ADDR, 8'hFF, 1'b1, "d200 rd_addr FF");
    send(1, RD_ADDR, 8'hC7, 1'b0, "d200 rd_addr C7");
    rd(1, 8'h01, "d200 rd C7");
    rd(1, 8'h02, "d200 rd 00");

    // no auto-increment: repeated reads of one location
    send(2, WR_ADDR, 8'h20, 1'b0, "noinc wr_addr");
    send(2, WR_DATA, 8'h3C, 1'b0, "noinc wr");
    send(2, RD_ADDR, 8'h20, 1'b0, "noinc rd_addr");
    rd(2, 8'h3C, "noinc rd1");
    rd(2, 8'h3C, "noinc rd2");
    rd(2, 8'h3C, "noinc rd3");
    @(negedge clk);
    check("noinc idle dout hold", dout[2], 8'h3C);
    check("noinc idle tx_valid", txv[2], 1'b0);

    // basic write/read
    send(0, WR_ADDR, 8'h10, 1'b0, "t1 wr_addr");
    send(0, WR_DATA, 8'hA5, 1'b0, "t1 wr");
    send(0, RD_ADDR, 8'h10, 1'b0, "t1 rd_addr");
    rd(0, 8'hA5, "t1 rd");

    // burst across the top of a power-of-2 array
    send(0, WR_ADDR, 8'hFF, 1'b0, "t2 wr_addr");
    send(0, WR_DATA, 8'h11, 1'b0, "t2 wr FF");
    send(0, WR_DATA, 8'h22, 1'b0, "t2 wr 00");
    send(0, RD_ADDR, 8'hFF, 1'b0, "t2 rd_addr");
    rd(0, 8'h11, "t2 rd FF");
    rd(0, 8'h22, "t2 rd 00");

    // write immediately followed by read of the same address
    send(0, WR_ADDR, 8'h30, 1'b0, "raw wr_addr");
    send(0, RD_ADDR, 8'h30, 1'b0, "raw rd_addr");
    send(0, WR_DATA, 8'h66, 1'b0, "raw wr");
    rd(0, 8'h66, "raw rd");

    // after reset, data commands error until re-addressed
    do_reset("reset1");
    send(0, RD_DATA, 8'h00, 1'b1, "t3 rd unarmed");
    check("t3 dout after err", dout[0], 8'h00);
    send(0, WR_DATA, 8'h5A, 1'b1, "t3 wr unarmed");
    send(0, RD_ADDR, 8'h00, 1'b0, "t3 rd_addr");
    rd(0, 8'h22, "t3 mem00 kept");

    // reset mid-burst disarms the write pointer
    send(0, WR_ADDR, 8'h40, 1'b0, "t6 wr_addr");
    send(0, WR_DATA, 8'h77, 1'b0, "t6 wr");
    send(0, WR_ADDR, 8'h40, 1'b0, "t6 wr_addr again");
    do_reset("reset2");
    send(0, WR_DATA, 8'h99, 1'b1, "t6 wr after reset");
    send(0, RD_ADDR, 8'h40, 1'b0, "t6 rd_addr");
    rd(0, 8'h77, "t6 mem40 kept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
